// File: rtl/mem_sched_pkg.sv
// rtl/mem_sched_pkg.sv - shared types and sizing for the DRAM request scheduler
package mem_sched_pkg;

    // Cache geometry and bus width are carried for reference only.
    localparam int A                  = 8;
    localparam int B                  = 64;
    localparam int C                  = 16384;
    localparam int BUS_WIDTH          = 16;
    localparam int BANK_GROUPS        = 8;
    localparam int BANKS_PER_GROUP    = 8;
    localparam int ROW_BITS           = 8;
    localparam int COL_BITS           = 4;
    localparam int PADDR_BITS         = 19;
    localparam int QUEUE_SIZE         = 16;
    localparam int ACTIVATION_LATENCY = 8;
    localparam int PRECHARGE_LATENCY  = 5;
    localparam int BANKS              = BANK_GROUPS * BANKS_PER_GROUP;

    localparam int DATA_W        = B * 8;
    localparam int BG_BITS       = $clog2(BANK_GROUPS);
    localparam int BK_BITS       = $clog2(BANKS_PER_GROUP);
    localparam int BANK_IDX_BITS = $clog2(BANKS);
    localparam int QIDX_BITS     = $clog2(QUEUE_SIZE);
    localparam int TIMER_BITS    = 4;

    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_ACTIVATE  = 3'd1,
        CMD_READ      = 3'd2,
        CMD_WRITE     = 3'd3,
        CMD_PRECHARGE = 3'd4
    } cmd_e;

    typedef struct packed {
        logic [BG_BITS-1:0]  bank_group;
        logic [BK_BITS-1:0]  bank;
        logic [ROW_BITS-1:0] row;
        logic [COL_BITS-1:0] col;
        logic                write;
        logic [DATA_W-1:0]   data;
    } mem_req_t;

    function automatic logic [BANK_IDX_BITS-1:0] bank_index(
        input logic [BG_BITS-1:0] bg,
        input logic [BK_BITS-1:0] bk
    );
        return BANK_IDX_BITS'(bg) * BANK_IDX_BITS'(BANKS_PER_GROUP) + BANK_IDX_BITS'(bk);
    endfunction

endpackage

// File: rtl/request_queue.sv
// rtl/request_queue.sv - shift-array FIFO of mem_req_t with same-edge push/pop
// ROW_HIT_FIRST_EN exposes all entries and allows popping from any index.
module request_queue
    import mem_sched_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 i_push,
    input  mem_req_t             i_req,
    input  logic                 i_pop,
`ifdef ROW_HIT_FIRST_EN
    input  logic [QIDX_BITS-1:0] i_pop_idx,
    output mem_req_t             o_entries [QUEUE_SIZE],
    output logic [QIDX_BITS:0]   o_count,
`endif
    output mem_req_t             o_head,
    output logic                 o_empty
);

    mem_req_t               r_mem [QUEUE_SIZE];
    logic [QIDX_BITS:0]     r_count;
    logic [QIDX_BITS-1:0]   w_pop_idx;
    logic [QIDX_BITS-1:0]   w_wr_idx;
    logic                   w_full;
    logic                   w_push_ok;

`ifdef ROW_HIT_FIRST_EN
    assign w_pop_idx = i_pop_idx;
    assign o_entries = r_mem;
    assign o_count   = r_count;
`else
    assign w_pop_idx = '0;
`endif

    assign w_full    = (r_count == (QIDX_BITS+1)'(QUEUE_SIZE));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[0];
    // A pop frees a slot on the same edge, so a full queue still accepts.
    assign w_push_ok = i_push && (!w_full || i_pop);
    assign w_wr_idx  = QIDX_BITS'(r_count - {{QIDX_BITS{1'b0}}, i_pop});

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + {{QIDX_BITS{1'b0}}, w_push_ok} - {{QIDX_BITS{1'b0}}, i_pop};
        end
    end

    always_ff @(posedge clk_in) begin
        if (i_pop) begin
            for (int i = 0; i < QUEUE_SIZE - 1; i++) begin
                if (QIDX_BITS'(i) >= w_pop_idx) begin
                    r_mem[i] <= r_mem[i+1];
                end
            end
        end
        if (w_push_ok) begin
            r_mem[w_wr_idx] <= i_req;
        end
    end

endmodule

// File: rtl/request_scheduler.sv
// rtl/request_scheduler.sv - single-channel DRAM command scheduler with per-bank row/timer tracking
// ROW_HIT_FIRST_EN selects FR-FCFS; undefined gives strict in-order head scheduling.
module request_scheduler
    import mem_sched_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [BG_BITS-1:0]    bank_group_in,
    input  logic [BK_BITS-1:0]    bank_in,
    input  logic [ROW_BITS-1:0]   row_in,
    input  logic [COL_BITS-1:0]   col_in,
    input  logic                  valid_in,
    input  logic                  write_in,
    input  logic [DATA_W-1:0]     val_in,
    input  logic                  cmd_ready,
    output logic [PADDR_BITS-1:0] addr_out,
    output logic [BG_BITS-1:0]    bank_group_out,
    output logic [BK_BITS-1:0]    bank_out,
    output logic [ROW_BITS-1:0]   row_out,
    output logic [COL_BITS-1:0]   col_out,
    output logic [DATA_W-1:0]     val_out,
    output logic [2:0]            cmd_out,
    output logic                  valid_out
);

    mem_req_t                 w_req;
    mem_req_t                 w_head;
    mem_req_t                 w_sel;
    logic                     w_empty;
    logic                     w_issue;
    logic                     w_pop;
    cmd_e                     w_cmd;
    logic [QIDX_BITS-1:0]     w_pop_idx;
    logic [BANK_IDX_BITS-1:0] w_hbank;
    logic [BANK_IDX_BITS-1:0] w_sbank;

    logic [BANKS-1:0]         r_open;
    logic [ROW_BITS-1:0]      r_row   [BANKS];
    logic [TIMER_BITS-1:0]    r_timer [BANKS];

    assign w_req = '{bank_group: bank_group_in, bank: bank_in, row: row_in,
                     col: col_in, write: write_in, data: val_in};

`ifdef ROW_HIT_FIRST_EN
    mem_req_t                 w_entries [QUEUE_SIZE];
    logic [QIDX_BITS:0]       w_count;
    logic [BANK_IDX_BITS-1:0] w_cbank;
`endif

    request_queue u_queue (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .i_push    (valid_in),
        .i_req     (w_req),
        .i_pop     (w_pop),
`ifdef ROW_HIT_FIRST_EN
        .i_pop_idx (w_pop_idx),
        .o_entries (w_entries),
        .o_count   (w_count),
`endif
        .o_head    (w_head),
        .o_empty   (w_empty)
    );

    assign w_hbank = bank_index(w_head.bank_group, w_head.bank);
    assign w_sbank = bank_index(w_sel.bank_group, w_sel.bank);

    always_comb begin
        w_sel     = w_head;
        w_issue   = 1'b0;
        w_cmd     = CMD_NOP;
        w_pop     = 1'b0;
        w_pop_idx = '0;
`ifdef ROW_HIT_FIRST_EN
        w_cbank   = '0;
`endif
        if (cmd_ready && !w_empty) begin
            if (r_timer[w_hbank] == '0) begin
                w_issue = 1'b1;
                if (!r_open[w_hbank]) begin
                    w_cmd = CMD_ACTIVATE;
                end else if (r_row[w_hbank] == w_head.row) begin
                    w_cmd = w_head.write ? CMD_WRITE : CMD_READ;
                    w_pop = 1'b1;
                end else begin
                    w_cmd = CMD_PRECHARGE;
                end
            end
`ifdef ROW_HIT_FIRST_EN
            else begin
                // Descending scan so the oldest ready row hit is the one left selected.
                for (int i = QUEUE_SIZE - 1; i >= 1; i--) begin
                    w_cbank = bank_index(w_entries[i].bank_group, w_entries[i].bank);
                    if ((QIDX_BITS+1)'(i) < w_count && r_open[w_cbank] &&
                        r_row[w_cbank] == w_entries[i].row && r_timer[w_cbank] == '0) begin
                        w_sel     = w_entries[i];
                        w_issue   = 1'b1;
                        w_cmd     = w_entries[i].write ? CMD_WRITE : CMD_READ;
                        w_pop     = 1'b1;
                        w_pop_idx = QIDX_BITS'(i);
                    end
                end
            end
`endif
        end
    end

    // Timers load latency-1 so the follow-up command lands exactly latency edges later.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_open <= '0;
            for (int b = 0; b < BANKS; b++) begin
                r_row[b]   <= '0;
                r_timer[b] <= '0;
            end
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                if (r_timer[b] != '0) begin
                    r_timer[b] <= r_timer[b] - 1'b1;
                end
            end
            if (w_issue && w_cmd == CMD_ACTIVATE) begin
                r_open[w_sbank]  <= 1'b1;
                r_row[w_sbank]   <= w_sel.row;
                r_timer[w_sbank] <= TIMER_BITS'(ACTIVATION_LATENCY - 1);
            end else if (w_issue && w_cmd == CMD_PRECHARGE) begin
                r_open[w_sbank]  <= 1'b0;
                r_timer[w_sbank] <= TIMER_BITS'(PRECHARGE_LATENCY - 1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_out      <= 1'b0;
            cmd_out        <= CMD_NOP;
            addr_out       <= '0;
            bank_group_out <= '0;
            bank_out       <= '0;
            row_out        <= '0;
            col_out        <= '0;
            val_out        <= '0;
        end else begin
            valid_out <= w_issue;
            cmd_out   <= w_cmd;
            if (w_issue) begin
                addr_out       <= PADDR_BITS'({w_sel.bank_group, w_sel.bank, w_sel.row, w_sel.col});
                bank_group_out <= w_sel.bank_group;
                bank_out       <= w_sel.bank;
                row_out        <= w_sel.row;
                col_out        <= w_sel.col;
                val_out        <= (w_cmd == CMD_WRITE) ? w_sel.data : '0;
            end
        end
    end

endmodule

// File: tb/tb_request_scheduler.sv
// tb/tb_request_scheduler.sv - directed and randomized checks of request_scheduler against a queue/timestamp model
module tb_request_scheduler;
    import mem_sched_pkg::*;

    logic                  clk_in = 1'b0;
    logic                  rst_in;
    logic [BG_BITS-1:0]    bank_group_in;
    logic [BK_BITS-1:0]    bank_in;
    logic [ROW_BITS-1:0]   row_in;
    logic [COL_BITS-1:0]   col_in;
    logic                  valid_in;
    logic                  write_in;
    logic [DATA_W-1:0]     val_in;
    logic                  cmd_ready;
    logic [PADDR_BITS-1:0] addr_out;
    logic [BG_BITS-1:0]    bank_group_out;
    logic [BK_BITS-1:0]    bank_out;
    logic [ROW_BITS-1:0]   row_out;
    logic [COL_BITS-1:0]   col_out;
    logic [DATA_W-1:0]     val_out;
    logic [2:0]            cmd_out;
    logic                  valid_out;

    request_scheduler dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .bank_group_in(bank_group_in), .bank_in(bank_in), .row_in(row_in), .col_in(col_in),
        .valid_in(valid_in), .write_in(write_in), .val_in(val_in), .cmd_ready(cmd_ready),
        .addr_out(addr_out), .bank_group_out(bank_group_out), .bank_out(bank_out),
        .row_out(row_out), .col_out(col_out), .val_out(val_out), .cmd_out(cmd_out),
        .valid_out(valid_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int                bg;
        int                bk;
        int                row;
        int                col;
        bit                wr;
        logic [DATA_W-1:0] data;
    } mreq_t;

    mreq_t             mq[$];
    bit                m_open  [BANKS];
    int                m_row   [BANKS];
    longint            m_ready [BANKS];
    longint            cyc = 0;
    bit                e_valid;
    int                e_cmd, e_bg, e_bk, e_row, e_col;
    logic [DATA_W-1:0] e_val;
    int                n_vec = 0;
    int                n_bad = 0;
    longint            log_cyc[$];
    int                log_cmd[$];
    int                log_col[$];

    task automatic check(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int b = 0; b < BANKS; b++) begin
            m_open[b]  = 1'b0;
            m_row[b]   = 0;
            m_ready[b] = 0;
        end
        e_valid = 1'b0; e_cmd = 0; e_bg = 0; e_bk = 0; e_row = 0; e_col = 0; e_val = '0;
    endtask

    task automatic issue(input mreq_t h, input int c);
        e_valid = 1'b1;
        e_cmd   = c;
        e_bg    = h.bg;
        e_bk    = h.bk;
        e_row   = h.row;
        e_col   = h.col;
        e_val   = (c == 3) ? h.data : '0;
    endtask

    // Bank readiness is tracked as the absolute edge number at which the bank may next be commanded.
    task automatic model_edge();
        mreq_t h;
        int    b;
        cyc++;
        e_valid = 1'b0;
        e_cmd   = 0;
        if (cmd_ready && mq.size() > 0) begin
            h = mq[0];
            b = h.bg * BANKS_PER_GROUP + h.bk;
            if (cyc >= m_ready[b]) begin
                if (!m_open[b]) begin
                    m_open[b] = 1'b1; m_row[b] = h.row; m_ready[b] = cyc + ACTIVATION_LATENCY;
                    issue(h, 1);
                end else if (m_row[b] == h.row) begin
                    issue(h, h.wr ? 3 : 2);
                    void'(mq.pop_front());
                end else begin
                    m_open[b] = 1'b0; m_ready[b] = cyc + PRECHARGE_LATENCY;
                    issue(h, 4);
                end
            end
`ifdef ROW_HIT_FIRST_EN
            else begin
                for (int i = 1; i < mq.size(); i++) begin
                    b = mq[i].bg * BANKS_PER_GROUP + mq[i].bk;
                    if (m_open[b] && m_row[b] == mq[i].row && cyc >= m_ready[b]) begin
                        issue(mq[i], mq[i].wr ? 3 : 2);
                        mq.delete(i);
                        break;
                    end
                end
            end
`endif
        end
        if (valid_in && mq.size() < QUEUE_SIZE) begin
            h.bg = int'(bank_group_in); h.bk = int'(bank_in); h.row = int'(row_in);
            h.col = int'(col_in); h.wr = write_in; h.data = val_in;
            mq.push_back(h);
        end
    endtask

    task automatic check_outputs();
        int e_addr;
        e_addr = e_bg * 32768 + e_bk * 4096 + e_row * 16 + e_col;
        check("valid_out", DATA_W'(valid_out), DATA_W'(e_valid));
        check("cmd_out", DATA_W'(cmd_out), DATA_W'(e_cmd));
        check("bank_group_out", DATA_W'(bank_group_out), DATA_W'(e_bg));
        check("bank_out", DATA_W'(bank_out), DATA_W'(e_bk));
        check("row_out", DATA_W'(row_out), DATA_W'(e_row));
        check("col_out", DATA_W'(col_out), DATA_W'(e_col));
        check("addr_out", DATA_W'(addr_out), DATA_W'(e_addr));
        check("val_out", val_out, e_val);
        if (valid_out) begin
            log_cyc.push_back(cyc);
            log_cmd.push_back(int'(cmd_out));
            log_col.push_back(int'(col_out));
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        if (rst_in) model_reset();
        else model_edge();
        @(negedge clk_in);
        check_outputs();
    endtask

    task automatic clear_log();
        log_cyc.delete(); log_cmd.delete(); log_col.delete();
    endtask

    task automatic push_req(input int bg, input int bk, input int row, input int col,
                            input bit wr, input logic [DATA_W-1:0] data);
        bank_group_in = BG_BITS'(bg); bank_in = BK_BITS'(bk); row_in = ROW_BITS'(row);
        col_in = COL_BITS'(col); write_in = wr; val_in = data; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic do_reset();
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] pat;
        rst_in = 1'b1; valid_in = 1'b0; write_in = 1'b0; cmd_ready = 1'b0;
        bank_group_in = '0; bank_in = '0; row_in = '0; col_in = '0; val_in = '0;
        model_reset();
        do_reset();

        // Write activate then write after the activation gap.
        cmd_ready = 1'b1;
        clear_log();
        pat = {8{64'hA5A5A5A5A5A5A5A5}};
        push_req(3, 2, 'h55, 'hA, 1'b1, pat);
        repeat (12) step();
        check("s1_ncmd", DATA_W'(log_cmd.size()), DATA_W'(2));
        check("s1_act", DATA_W'(log_cmd[0]), DATA_W'(1));
        check("s1_write", DATA_W'(log_cmd[1]), DATA_W'(3));
        check("s1_gap", DATA_W'(log_cyc[1] - log_cyc[0]), DATA_W'(8));

        // Two row hits behind one activate, then a row conflict.
        clear_log();
        push_req(2, 1, 'hF0, 6, 1'b0, rand_data());
        push_req(2, 1, 'hF0, 1, 1'b0, rand_data());
        repeat (12) step();
        check("s2_ncmd", DATA_W'(log_cmd.size()), DATA_W'(3));
        check("s2_act", DATA_W'(log_cmd[0]), DATA_W'(1));
        check("s2_rd6_gap", DATA_W'(log_cyc[1] - log_cyc[0]), DATA_W'(8));
        check("s2_rd6_col", DATA_W'(log_col[1]), DATA_W'(6));
        check("s2_rd1_gap", DATA_W'(log_cyc[2] - log_cyc[1]), DATA_W'(1));
        check("s2_rd1_col", DATA_W'(log_col[2]), DATA_W'(1));
        clear_log();
        push_req(2, 1, 'h0F, 8, 1'b0, rand_data());
        repeat (16) step();
        check("s3_ncmd", DATA_W'(log_cmd.size()), DATA_W'(3));
        check("s3_pre", DATA_W'(log_cmd[0]), DATA_W'(4));
        check("s3_act_gap", DATA_W'(log_cyc[1] - log_cyc[0]), DATA_W'(5));
        check("s3_rd_gap", DATA_W'(log_cyc[2] - log_cyc[1]), DATA_W'(8));
        check("s3_rd_col", DATA_W'(log_col[2]), DATA_W'(8));

        // cmd_ready held low for 20 edges after an activate.
        clear_log();
        push_req(1, 1, 3, 2, 1'b0, rand_data());
        step();
        cmd_ready = 1'b0;
        push_req(1, 1, 3, 5, 1'b1, rand_data());
        repeat (19) step();
        check("s4_hold_ncmd", DATA_W'(log_cmd.size()), DATA_W'(1));
        cmd_ready = 1'b1;
        repeat (4) step();
        check("s4_ncmd", DATA_W'(log_cmd.size()), DATA_W'(3));
        check("s4_resume_gap", DATA_W'(log_cyc[1] - log_cyc[0]), DATA_W'(21));
        check("s4_write", DATA_W'(log_cmd[2]), DATA_W'(3));

        // Overfill: 17 pushes without pops keep 16.
        cmd_ready = 1'b0;
        for (int i = 0; i < 17; i++)
            push_req($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255),
                     $urandom_range(0, 15), 1'($urandom_range(0, 1)), rand_data());
        check("full_count", DATA_W'(dut.u_queue.r_count), DATA_W'(QUEUE_SIZE));
        cmd_ready = 1'b1;
        repeat (300) step();
        check("drain_count", DATA_W'(dut.u_queue.r_count), DATA_W'(0));

        // Asynchronous reset in the middle of a burst.
        cmd_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            push_req($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255),
                     $urandom_range(0, 15), 1'($urandom_range(0, 1)), rand_data());
        rst_in = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("rst_count", DATA_W'(dut.u_queue.r_count), DATA_W'(0));
        step();
        rst_in = 1'b0;
        cmd_ready = 1'b1;
        repeat (10) step();

        // Random traffic over a small bank/row space to mix hits and conflicts.
        for (int n = 0; n < 3000; n++) begin
            valid_in      = 1'($urandom_range(0, 1));
            bank_group_in = BG_BITS'($urandom_range(0, 1));
            bank_in       = BK_BITS'($urandom_range(0, 1));
            row_in        = ROW_BITS'($urandom_range(0, 2));
            col_in        = COL_BITS'($urandom_range(0, 15));
            write_in      = 1'($urandom_range(0, 1));
            val_in        = rand_data();
            cmd_ready     = ($urandom_range(0, 4) != 0);
            step();
        end
        valid_in = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/request_scheduler.md
Name: request_scheduler

Overview:
- Single-channel DRAM command scheduler between the memory-request front end and the DRAM command controller.
- Each cycle it accepts at most one decoded request (bank group, bank, row, column, read/write, one cache line of data) into a queue.
- Tracks the open row and the timing of every bank.
- Emits one DRAM command per cycle (ACTIVATE, READ, WRITE, PRECHARGE), gated by the controller's cmd_ready.

Parameters:
- A, 8, cache associativity; informational only, unused by logic.
- B, 64, line size in bytes; data width is B*8 (512).
- C, 16384, cache capacity in bytes; informational only.
- BUS_WIDTH, 16, DRAM data-bus width in bits; informational only.
- BANK_GROUPS, 8, number of bank groups.
- BANKS_PER_GROUP, 8, banks in each group.
- ROW_BITS, 8, row address width.
- COL_BITS, 4, column address width.
- PADDR_BITS, 19, width of the flat address output.
- QUEUE_SIZE, 16, request queue depth (power of two).
- ACTIVATION_LATENCY, 8, cycles from ACTIVATE to the next command on that bank.
- PRECHARGE_LATENCY, 5, cycles from PRECHARGE to the next command on that bank.
- BANKS, 64, total banks; must equal BANK_GROUPS*BANKS_PER_GROUP.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset
- bank_group_in  in  clog2(BANK_GROUPS)  request bank group
- bank_in  in  clog2(BANKS_PER_GROUP)  request bank
- row_in  in  ROW_BITS  request row
- col_in  in  COL_BITS  request column
- valid_in  in  1  request valid this cycle
- write_in  in  1  1 = write, 0 = read
- val_in  in  B*8  write data
- cmd_ready  in  1  controller can take a command
- addr_out  out  PADDR_BITS  {bank_group, bank, row, col}, zero-extended in the MSBs
- bank_group_out  out  clog2(BANK_GROUPS)  command bank group
- bank_out  out  clog2(BANKS_PER_GROUP)  command bank
- row_out  out  ROW_BITS  command row
- col_out  out  COL_BITS  command column
- val_out  out  B*8  write data on WRITE, else 0
- cmd_out  out  3  0 NOP, 1 ACTIVATE, 2 READ, 3 WRITE, 4 PRECHARGE
- valid_out  out  1  command valid, one-cycle pulse

Interface: one clock, clk_in; rst_in is asynchronous, active-high.

Behaviour:
- Reset:
  - All outputs 0 (cmd_out = NOP).
  - Queue emptied.
  - All banks closed, all bank timers 0.
  - Reset asserted mid-operation discards queued requests and bank state immediately.
- Enqueue:
  - valid_in sampled at a rising edge pushes a request.
  - No backpressure port: if the queue is full and no pop occurs on that edge, the request is dropped.
  - A push and a pop on the same edge are both honoured, including when the queue is full.
- Bank index = bank_group*BANKS_PER_GROUP + bank.
- Per-bank state: open flag, open row, countdown timer. Timers decrement every cycle down to 0, regardless of cmd_ready.
- Scheduling: in-order; only the queue head is considered. At an edge with cmd_ready=1, a non-empty queue, and the head bank's timer = 0:
  - Bank closed: issue ACTIVATE(row); mark bank open with that row; load timer so that the next command to that bank has valid_out exactly ACTIVATION_LATENCY cycles later.
  - Bank open, row matches: issue READ or WRITE per write_in; pop the head.
  - Bank open, row differs: issue PRECHARGE; mark bank closed; next command spaced PRECHARGE_LATENCY cycles later.
- Outputs:
  - Registered; valid_out is high for exactly one cycle per command and 0 otherwise.
  - With valid_out=0, the other outputs hold their last values, except cmd_out, which is NOP.
- Latency:
  - A request accepted at edge k can produce its first command at edge k+1 at the earliest.
  - No bypass from an empty queue.
- cmd_ready=0: no command issued and no state change apart from timers and enqueue.
- Row-hit READ/WRITE commands are not timed; back-to-back hits issue on consecutive cycles.

Optional Feature:
- Macro ROW_HIT_FIRST_EN.
- When defined: FR-FCFS. If the head is not issuable, the oldest queued request that is a row hit on an open bank with timer 0 issues instead and is removed from the middle of the queue, with order preserved.
- When undefined: strict in-order head-only scheduling as above.

Decomposition:
- Package mem_sched_pkg: cmd_e enum (NOP/ACTIVATE/READ/WRITE/PRECHARGE, 3 bits), mem_req_t struct (bank_group, bank, row, col, write, data), latency constants.
- One sub-module, request_queue: FIFO of mem_req_t with count, full, empty, and same-edge push/pop.

Test Plan (default parameters):
- Write to bank group 3, bank 2, row 0x55, col 0xA, data 0x...A5A5A5A5A5A5A5A5, cmd_ready=1 -> ACTIVATE bank group 3, bank 2, row 0x55; 8 cycles later WRITE col 0xA with val_out = that data.
- Read bank group 2, bank 1, row 0xF0, col 6, then col 1 -> one ACTIVATE; READ col 6 8 cycles later; READ col 1 on the next cycle.
- Then read row 0x0F, col 8, same bank -> PRECHARGE; 5 cycles later ACTIVATE row 0x0F; 8 cycles later READ col 8.
- Hold cmd_ready=0 for 20 cycles with requests queued -> valid_out stays 0; on release, commands resume, with elapsed timers counted.
- Push 17 requests with no pops -> count 16 and the 17th is dropped; assert rst_in mid-burst -> outputs 0 and the queue empty at once.
